// File: rtl/jam_pkg.sv
//------------------------------------------------------------------------------
// jam_pkg : shared constants and state encoding for the JAM cost server
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package jam_pkg;

  localparam int N_IDX       = 8;
  localparam int IDX_W       = 3;
  localparam int COST_W      = 7;
  localparam int MINCOST_W   = 10;
  localparam int MATCH_W     = 4;
  localparam int TABLE_DEPTH = 64;
  localparam int ADDR_W      = 2 * IDX_W;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/jam_cost_server_if.sv
//------------------------------------------------------------------------------
// jam_cost_server_if : table load channel plus JAM lookup/result signals
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface jam_cost_server_if;
  import jam_pkg::*;

  logic                 load_valid;
  logic [COST_W-1:0]    load_data;
  logic                 load_ready;
  logic [IDX_W-1:0]     W;
  logic [IDX_W-1:0]     J;
  logic [COST_W-1:0]    Cost;
  logic                 JAM_RST;
  logic                 Valid;
  logic [MATCH_W-1:0]   MatchCount;
  logic [MINCOST_W-1:0] MinCost;

  modport slave (
    input  load_valid, load_data, W, J, Valid, MatchCount, MinCost,
    output load_ready, Cost, JAM_RST
  );

  modport master (
    output load_valid, load_data, W, J, Valid, MatchCount, MinCost,
    input  load_ready, Cost, JAM_RST
  );

endinterface

`default_nettype wire

// File: rtl/jam_cost_ram.sv
//------------------------------------------------------------------------------
// jam_cost_ram : cost table storage, synchronous write, asynchronous read
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module jam_cost_ram
  import jam_pkg::*;
#(
  parameter int DATA_W = COST_W,
  parameter int DEPTH  = TABLE_DEPTH,
  parameter int AW     = ADDR_W
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/jam_cost_server.sv
//------------------------------------------------------------------------------
// jam_cost_server : loads the 8x8 cost table, releases JAM, serves lookups
//                   and captures the JAM result or a run timeout.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module jam_cost_server #(
  parameter int                COST_W  = jam_pkg::COST_W,
  parameter int                CYC_W   = 20,
  parameter logic [CYC_W-1:0]  TIMEOUT = 20'hFFFFF
) (
  input  logic                           CLK,
  input  logic                           RST,
  jam_cost_server_if.slave               jam,
  output logic                           done,
  output logic                           timeout,
  output logic [jam_pkg::MATCH_W-1:0]    result_count,
  output logic [jam_pkg::MINCOST_W-1:0]  result_cost,
  output logic [CYC_W-1:0]               run_cycles
);
  import jam_pkg::*;

  localparam logic [CYC_W-1:0] c_LAST_CYC = TIMEOUT - CYC_W'(1);

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [ADDR_W-1:0]    r_idx;
  logic                 w_load_hs;
  logic [COST_W-1:0]    w_rdata;
  logic                 r_jam_rst;
  logic                 r_done;
  logic                 r_timeout;
  logic [MATCH_W-1:0]   r_result_count;
  logic [MINCOST_W-1:0] r_result_cost;
  logic [CYC_W-1:0]     r_run_cycles;

  assign w_load_hs = jam.load_valid && (r_state == ST_LOAD);

  jam_cost_ram #(
    .DATA_W (COST_W),
    .DEPTH  (TABLE_DEPTH),
    .AW     (ADDR_W)
  ) u_ram (
    .CLK   (CLK),
    .we    (w_load_hs),
    .waddr (r_idx),
    .wdata (jam.load_data),
    .raddr ({jam.W, jam.J}),
    .rdata (w_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_load_hs && (r_idx == ADDR_W'(TABLE_DEPTH - 1))) begin
          w_next = ST_RELEASE;
        end
      end
      ST_RELEASE: w_next = ST_RUN;
      ST_RUN: begin
        if (jam.Valid || (r_run_cycles == c_LAST_CYC)) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_DONE;
    endcase
  end

  always_comb begin
    jam.load_ready = (r_state == ST_LOAD);
    jam.Cost       = (r_state == ST_RUN) ? w_rdata : '0;
  end

  // JAM_RST is registered from the next state so it drops exactly on RUN entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx          <= '0;
      r_jam_rst      <= 1'b1;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
      r_result_count <= '0;
      r_result_cost  <= '0;
      r_run_cycles   <= '0;
    end else begin
      r_jam_rst <= (w_next != ST_RUN);
      if (w_load_hs) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
      if (r_state == ST_RUN) begin
        if (r_run_cycles != '1) begin
          r_run_cycles <= r_run_cycles + CYC_W'(1);
        end
        // Valid wins over a coincident timeout
        if (jam.Valid) begin
          r_result_count <= jam.MatchCount;
          r_result_cost  <= jam.MinCost;
          r_done         <= 1'b1;
        end else if (r_run_cycles == c_LAST_CYC) begin
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign jam.JAM_RST   = r_jam_rst;
  assign done          = r_done;
  assign timeout       = r_timeout;
  assign result_count  = r_result_count;
  assign result_cost   = r_result_cost;
  assign run_cycles    = r_run_cycles;

endmodule

`default_nettype wire

// File: tb/tb_jam_cost_server.sv
//------------------------------------------------------------------------------
// tb_jam_cost_server : scoreboard bench for jam_cost_server (TIMEOUT = 100)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jam_cost_server;
  import jam_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        done;
  logic        timeout;
  logic [3:0]  result_count;
  logic [9:0]  result_cost;
  logic [19:0] run_cycles;

  always #5 CLK = ~CLK;

  jam_cost_server_if bus ();

  jam_cost_server #(
    .COST_W  (7),
    .CYC_W   (20),
    .TIMEOUT (20'd100)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .jam          (bus),
    .done         (done),
    .timeout      (timeout),
    .result_count (result_count),
    .result_cost  (result_cost),
    .run_cycles   (run_cycles)
  );

  typedef enum int {K_LDRDY, K_JRST, K_DONE, K_TMO, K_RCNT, K_RCOST, K_COST, K_CYC} kind_t;
  typedef struct { kind_t kind; int exp; } exp_t;
  typedef struct { int tmo; int cnt; int cost; } res_t;

  exp_t sq[$];
  res_t rq[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  function automatic int actual(kind_t k);
    case (k)
      K_LDRDY: return int'(bus.load_ready);
      K_JRST:  return int'(bus.JAM_RST);
      K_DONE:  return int'(done);
      K_TMO:   return int'(timeout);
      K_RCNT:  return int'(result_count);
      K_RCOST: return int'(result_cost);
      K_COST:  return int'(bus.Cost);
      default: return int'(run_cycles);
    endcase
  endfunction

  function automatic string kname(kind_t k);
    case (k)
      K_LDRDY: return "load_ready";
      K_JRST:  return "JAM_RST";
      K_DONE:  return "done";
      K_TMO:   return "timeout";
      K_RCNT:  return "result_count";
      K_RCOST: return "result_cost";
      K_COST:  return "Cost";
      default: return "run_cycles";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares result captures on a done rise, then drains queued samples
  always @(negedge CLK) begin : mon
    res_t r;
    exp_t e;
    if (done && !prev_done) begin
      if (rq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        r = rq.pop_front();
        check("res_timeout", int'(timeout), r.tmo);
        check("res_count", int'(result_count), r.cnt);
        check("res_cost", int'(result_cost), r.cost);
      end
    end
    prev_done = done;
    while (sq.size() > 0) begin
      e = sq.pop_front();
      check(kname(e.kind), actual(e.kind), e.exp);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_val(input kind_t k, input int v);
    sq.push_back('{kind: k, exp: v});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic bubble;
    RST            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.W          = '0;
    bus.J          = '0;
    bus.Valid      = 1'b0;
    bus.MatchCount = '0;
    bus.MinCost    = '0;
    tick();
    tick();
    exp_val(K_LDRDY, 1); exp_val(K_JRST, 1); exp_val(K_DONE, 0); exp_val(K_TMO, 0);
    exp_val(K_RCNT, 0);  exp_val(K_RCOST, 0); exp_val(K_CYC, 0); exp_val(K_COST, 0);
    tick();
    RST = 1'b0;

    // Back-to-back load of 8w+j
    for (int i = 0; i < 64; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 7'(i);
      if (i == 63) exp_val(K_LDRDY, 1);
      tick();
    end
    bus.load_valid = 1'b0;
    exp_val(K_LDRDY, 0); exp_val(K_JRST, 1); exp_val(K_CYC, 0);
    tick();
    exp_val(K_JRST, 0); exp_val(K_CYC, 0);
    bus.W = 3'd3; bus.J = 3'd5;
    exp_val(K_COST, 29);
    tick();
    exp_val(K_CYC, 1);
    bus.W = 3'd7; bus.J = 3'd7;
    exp_val(K_COST, 63);
    tick();
    bus.Valid      = 1'b1;
    bus.MatchCount = 4'd2;
    bus.MinCost    = 10'd123;
    rq.push_back('{tmo: 0, cnt: 2, cost: 123});
    tick();
    bus.W = 3'd3; bus.J = 3'd5;
    exp_val(K_CYC, 3); exp_val(K_JRST, 1); exp_val(K_TMO, 0); exp_val(K_COST, 0);
    bus.MatchCount = 4'd5;
    bus.MinCost    = 10'd7;
    tick();
    bus.Valid = 1'b0;
    exp_val(K_RCNT, 2); exp_val(K_RCOST, 123); exp_val(K_DONE, 1);
    exp_val(K_CYC, 3); exp_val(K_LDRDY, 0);
    tick();

    // Restart, partial load of 30 junk entries, then asynchronous mid-cycle reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 7'd100;
      tick();
    end
    #2;
    RST = 1'b1;
    bus.load_valid = 1'b0;
    #1;
    exp_val(K_LDRDY, 1); exp_val(K_JRST, 1); exp_val(K_DONE, 0); exp_val(K_CYC, 0);
    tick();
    RST = 1'b0;

    // Load with bubbles; Valid toggles during LOAD and must be ignored
    n = 0;
    for (int c = 0; c < 400 && n < 64; c++) begin
      bubble         = ($urandom_range(0, 2) == 0);
      bus.load_valid = !bubble;
      bus.load_data  = bubble ? 7'h7F : 7'(n);
      bus.Valid      = 1'($urandom_range(0, 1));
      bus.MatchCount = 4'd9;
      bus.MinCost    = 10'd511;
      if (n == 63 && !bubble) exp_val(K_LDRDY, 1);
      tick();
      if (!bubble) n++;
    end
    check("load_handshakes", n, 64);
    bus.Valid      = 1'b0;
    bus.load_valid = 1'b0;
    exp_val(K_LDRDY, 0); exp_val(K_JRST, 1); exp_val(K_DONE, 0);
    exp_val(K_RCNT, 0);  exp_val(K_RCOST, 0);
    tick();

    // RUN with load_valid driven (ignored), then let it time out
    bus.load_valid = 1'b1;
    bus.load_data  = 7'h7F;
    bus.W = 3'd0; bus.J = 3'd5;
    exp_val(K_COST, 5); exp_val(K_LDRDY, 0); exp_val(K_JRST, 0);
    tick();
    bus.W = 3'd3; bus.J = 3'd5;
    exp_val(K_COST, 29);
    tick();
    bus.W = 3'd7; bus.J = 3'd7;
    exp_val(K_COST, 63);
    tick();
    bus.load_valid = 1'b0;
    rq.push_back('{tmo: 1, cnt: 0, cost: 0});
    for (int k = 0; k < 200 && !done; k++) tick();
    if (!done) begin
      check("timeout_wait", 0, 1);
    end else begin
      exp_val(K_CYC, 100); exp_val(K_TMO, 1); exp_val(K_JRST, 1);
    end
    tick();
    tick();
    check("scoreboard_drained", sq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder side of the JAM cost interface: holds the 8x8 worker/job cost table and answers each (W,J) request with Cost in the same cycle.
- Sequences one complete JAM run:
  - streams the table in over a valid/ready port,
  - holds the JAM core in reset until the table is complete,
  - serves lookups,
  - captures MatchCount/MinCost when JAM asserts Valid.
- Sits between the table source (bench or host loader) and the JAM core.

Parameters:
- COST_W, 7, width of one table entry and of Cost.
- CYC_W, 20, width of the run-cycle counter.
- TIMEOUT, 20'hFFFFF, number of RUN cycles without Valid before the run is aborted.

Ports:
- CLK  in  1  single clock, all flops on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- load_valid  in  1  load_data carries an entry.
- load_data  in  COST_W  table entry; entries arrive in row-major order, index = {w,j}.
- load_ready  out  1  server accepts an entry this cycle.
- W  in  3  worker index from JAM.
- J  in  3  job index from JAM.
- Cost  out  COST_W  table[{W,J}].
- JAM_RST  out  1  reset to the JAM core, driven high while the table is incomplete.
- Valid  in  1  JAM result strobe.
- MatchCount  in  4  JAM result.
- MinCost  in  10  JAM result.
- done  out  1  run finished, either by Valid or by timeout.
- timeout  out  1  run aborted by timeout.
- result_count  out  4  captured MatchCount.
- result_cost  out  10  captured MinCost.
- run_cycles  out  CYC_W  number of RUN cycles elapsed.

Behaviour:
- Reset is asynchronous, active-high. Register values while RST is asserted:
  - state = LOAD, load index = 0.
  - JAM_RST = 1.
  - done = 0, timeout = 0, result_count = 0, result_cost = 0, run_cycles = 0.
  - Table storage is not reset; its contents are undefined until loaded.
- States: LOAD -> RELEASE -> RUN -> DONE.
- LOAD:
  - load_ready = 1 (combinational from state).
  - A handshake (load_valid && load_ready) writes load_data to table[index] and increments index.
  - A cycle with no handshake leaves index and table unchanged.
  - The handshake at index 63 moves the state to RELEASE; index wraps to 0.
  - JAM_RST = 1. Cost = 0.
  - Valid is ignored.
- RELEASE:
  - Lasts one cycle. JAM_RST = 1 so JAM's synchronous reset is sampled with the table complete.
  - load_ready = 0.
  - Next state is RUN.
- RUN:
  - JAM_RST = 0 (registered: it falls on the edge that enters RUN).
  - Cost = table[{W,J}] combinationally, with zero latency; JAM accumulates Cost in the same cycle it drives W/J.
  - run_cycles increments each cycle and saturates at all-ones.
  - load_valid is ignored; load_ready = 0.
  - Valid == 1 in RUN: on that edge, capture result_count <= MatchCount and result_cost <= MinCost, set done <= 1, go to DONE.
  - Timeout applies only when Valid == 0: if run_cycles == TIMEOUT-1, set done <= 1 and timeout <= 1, go to DONE; result registers stay 0.
  - Valid takes priority over timeout when both occur in the same cycle.
- DONE:
  - Terminal state; held until RST.
  - done stays 1. JAM_RST = 1, freezing the core. Cost = 0. load_ready = 0.
  - Results are held; further Valid pulses are ignored.
- Reset mid-operation, in any state: immediately back to LOAD with index 0. The partially loaded table is kept but is overwritten by the new load.
- Width rules:
  - Table depth is 64, addressed by {W,J} (6 bits).
  - No arithmetic on Cost; the server only stores and returns entries.

Decomposition:
- jam_pkg holds:
  - state encoding constants,
  - N_IDX = 8, IDX_W = 3, COST_W = 7, MINCOST_W = 10, MATCH_W = 4,
  - TABLE_DEPTH = 64.
- Sub-module jam_cost_ram: 64 x COST_W storage, one synchronous write port (we, waddr, wdata), one asynchronous read port (raddr -> rdata), no reset.

Test Plan:
- Reset, then 64 back-to-back handshakes with entry = 8w + j:
  - load_ready falls on the edge after the 64th handshake.
  - JAM_RST stays 1 for one more cycle, then 0.
  - run_cycles starts counting.
- Load with random load_valid bubbles, then W=3, J=5 in RUN:
  - index advances only on handshakes.
  - Cost = 29 in the same cycle.
  - W=7, J=7 -> Cost = 63.
- Valid = 1 in RUN with MatchCount = 2, MinCost = 123:
  - next cycle done = 1, result_count = 2, result_cost = 123, timeout = 0, JAM_RST = 1.
  - A second Valid with other values does not change the results.
- TIMEOUT = 100 with Valid held at 0: after 100 RUN cycles, done = 1, timeout = 1, result_count = 0, result_cost = 0.
- RST asserted asynchronously (mid-cycle) after 30 loaded entries:
  - immediately load_ready = 1, JAM_RST = 1, done = 0.
  - A subsequent load writes from index 0 and ends after 64 handshakes.
- Valid pulsed during LOAD, and load_valid driven during RUN: both ignored; state, index and results unchanged.
